// File: rtl/lmh6401_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lmh6401_pkg : shared register constants, types and write-word formatter.
// Rev 1.0
// ----------------------------------------------------------------------------
package lmh6401_pkg;

  localparam logic [6:0] GAIN_REG_ADDR = 7'h02;

  typedef logic [5:0] atten_t;

  localparam atten_t ATTEN_MAX = 6'd32;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2
  } gain_state_e;

  function automatic logic [15:0] lmh6401_write_word(input logic [6:0] addr7,
                                                      input logic [7:0] data8);
    return {1'b0, addr7, data8};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching upward from last+1.
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [LW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = N; i >= 1; i--) begin
      cand = LW'((32'(last) + 32'(i)) % 32'(N));
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lmh6401_gain_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lmh6401_gain_ctrl : coalescing gain-update sequencer feeding lmh6401_spi.
// Rev 1.0
// ----------------------------------------------------------------------------
module lmh6401_gain_ctrl
  import lmh6401_pkg::*;
#(
  parameter  int     NUM_CHANNELS  = 4,
  parameter  atten_t DEFAULT_ATTEN = 6'd20,
  localparam int     AW            = $clog2(NUM_CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW-1:0]             s_addr,
  input  logic [5:0]                s_atten,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [AW-1:0]             m_addr,
  output logic [15:0]               m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy,
  output logic [6*NUM_CHANNELS-1:0] shadow_atten
);

  gain_state_e             state_q, state_d;
  logic [AW-1:0]           init_idx_q, init_idx_d;
  logic [AW-1:0]           last_q, last_d;
  logic                    m_valid_q, m_valid_d;
  logic [AW-1:0]           m_addr_q, m_addr_d;
  logic [15:0]             m_data_q, m_data_d;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  atten_t                  pend_val_q [NUM_CHANNELS];
  atten_t                  pend_val_d [NUM_CHANNELS];
  atten_t                  shadow_q   [NUM_CHANNELS];
  atten_t                  shadow_d   [NUM_CHANNELS];

  logic [AW-1:0] grant_idx;
  logic          grant_valid;
  logic          handshake;
  logic          accept;
  atten_t        req_val;
  atten_t        sent_val;
  atten_t        ref_val;

  assign handshake = m_valid_q && m_ready;
  assign accept    = s_valid && !reset;
  assign req_val   = (s_atten > ATTEN_MAX) ? ATTEN_MAX : s_atten;
  assign sent_val  = m_data_q[5:0];

  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req         (pending_q),
    .last        (last_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      last_q     <= AW'(NUM_CHANNELS - 1);
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      pending_q  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shadow_q[c]   <= DEFAULT_ATTEN;
        pend_val_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      last_q     <= last_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    last_d     = last_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;
    if (handshake) begin
      last_d = m_addr_q;
    end
    unique case (state_q)
      ST_INIT: begin
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
          m_addr_d  = init_idx_q;
          m_data_d  = lmh6401_write_word(GAIN_REG_ADDR, {2'b00, DEFAULT_ATTEN});
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          if (init_idx_q == AW'(NUM_CHANNELS - 1)) begin
            state_d = ST_ARB;
          end else begin
            init_idx_d = init_idx_q + AW'(1);
          end
        end
      end
      ST_ARB: begin
        if (grant_valid) begin
          m_valid_d = 1'b1;
          m_addr_d  = grant_idx;
          m_data_d  = lmh6401_write_word(GAIN_REG_ADDR, {2'b00, pend_val_q[grant_idx]});
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_ARB;
        end
      end
      default: begin
        state_d   = ST_INIT;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // A request is de-duplicated against the value the device will hold once any
  // word already in flight (or being loaded this cycle) for that channel lands.
  always_comb begin
    pending_d  = pending_q;
    pend_val_d = pend_val_q;
    shadow_d   = shadow_q;
    ref_val    = shadow_q[s_addr];
    if (m_valid_q && (m_addr_q == s_addr)) begin
      ref_val = sent_val;
    end else if (m_valid_d && (m_addr_d == s_addr)) begin
      ref_val = m_data_d[5:0];
    end
    if (handshake) begin
      shadow_d[m_addr_q] = sent_val;
      if (pend_val_q[m_addr_q] == sent_val) begin
        pending_d[m_addr_q] = 1'b0;
      end
    end
    if (accept) begin
      if (req_val != ref_val) begin
        pending_d[s_addr]  = 1'b1;
        pend_val_d[s_addr] = req_val;
      end else begin
        pending_d[s_addr] = 1'b0;
      end
    end
  end

  assign s_ready = !reset;
  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_data  = m_data_q;
  assign busy    = !reset && ((state_q != ST_ARB) || (|pending_q));

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_shadow
    assign shadow_atten[6*c +: 6] = shadow_q[c];
  end

endmodule
`default_nettype wire

// File: tb/tb_lmh6401_gain_ctrl.sv
`default_nettype none
// tb_lmh6401_gain_ctrl : directed and randomized checks against a request-level model
// (each channel must end at its last clamped request, with no redundant writes).
module tb_lmh6401_gain_ctrl;

  localparam int N = 4;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [1:0]  s_addr  = '0;
  logic [5:0]  s_atten = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  m_addr;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
  logic [23:0] shadow_atten;

  int total = 0;
  int bad   = 0;

  int          desired   [N];
  int          mshadow   [N];
  int          word_cnt  [N];
  logic [15:0] last_word [N];
  int          init_cnt;
  int          cyc = 0;
  int          hs_addr [$];
  int          hs_cyc  [$];
  bit          prev_hs, prev_stall;
  logic [1:0]  prev_a;
  logic [15:0] prev_d;
  int          exp_ord [5] = '{1, 2, 3, 0, 1};

  lmh6401_gain_ctrl #(.NUM_CHANNELS(N), .DEFAULT_ATTEN(6'd20)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_addr       (s_addr),
    .s_atten      (s_atten),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .shadow_atten (shadow_atten)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 32) ? 32 : v;
  endfunction

  // Reference model: tracks what each device holds and what it should end up holding.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      init_cnt   = 0;
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
      for (int c = 0; c < N; c++) begin
        desired[c] = 20;
        mshadow[c] = 20;
      end
    end else begin
      if (prev_hs) chk("gap_after_hs", m_valid, 0);
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_addr", m_addr, prev_a);
        chk("hold_data", m_data, prev_d);
      end
      if (m_valid && m_ready) begin
        hs_addr.push_back(int'(m_addr));
        hs_cyc.push_back(cyc);
        if (init_cnt < N) begin
          chk("init_addr", m_addr, init_cnt);
          chk("init_data", m_data, 16'h0214);
          init_cnt++;
        end else begin
          chk("word_fmt", m_data[15:6], 10'h008);
          chk("redundant_write", (int'(m_data[5:0]) != mshadow[m_addr]), 1);
          word_cnt[m_addr]++;
          last_word[m_addr] = m_data;
        end
        mshadow[m_addr] = int'(m_data[5:0]);
      end
      if (s_valid) desired[s_addr] = clamp(int'(s_atten));
      prev_hs    = m_valid && m_ready;
      prev_stall = m_valid && !m_ready;
      prev_a     = m_addr;
      prev_d     = m_data;
    end
  end

  task automatic req(input int a, input int v);
    s_valid = 1'b1;
    s_addr  = 2'(a);
    s_atten = 6'(v);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (!busy && !m_valid) quiet++;
      else quiet = 0;
    end
    chk("idle_reached", (quiet >= 3), 1);
  endtask

  task automatic wait_valid(input int a);
    int n;
    n = 0;
    while (!(m_valid && (a < 0 || int'(m_addr) == a)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", (m_valid && (a < 0 || int'(m_addr) == a)), 1);
  endtask

  task automatic check_shadow(input string tag);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("%s_target%0d", tag, c), shadow_atten[c*6 +: 6], desired[c]);
      chk($sformatf("%s_model%0d", tag, c), shadow_atten[c*6 +: 6], mshadow[c]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    for (int c = 0; c < N; c++) word_cnt[c] = 0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shadow", shadow_atten, {4{6'd20}});

    reset = 1'b0;
    #1;
    chk("rel_s_ready", s_ready, 1);
    chk("rel_busy", busy, 1);
    @(negedge clk);
    chk("first_valid", m_valid, 1);
    chk("first_addr", m_addr, 0);
    chk("first_data", m_data, 16'h0214);
    wait_idle();
    chk("init_words", init_cnt, 4);
    chk("init_busy", busy, 0);
    chk("init_shadow", shadow_atten, {4{6'd20}});

    // Request latency from an idle arbiter.
    req(0, 3);
    chk("lat_t_valid", m_valid, 0);
    chk("lat_t_busy", busy, 1);
    @(negedge clk);
    chk("lat_t1_valid", m_valid, 1);
    chk("lat_t1_addr", m_addr, 0);
    chk("lat_t1_data", m_data, 16'h0203);
    wait_idle();

    // Coalescing while the sink stalls on another channel.
    m_ready = 1'b0;
    req(0, 4);
    wait_valid(0);
    mark = word_cnt[2];
    req(2, 5);
    req(2, 9);
    req(2, 12);
    m_ready = 1'b1;
    wait_idle();
    chk("coal_count", word_cnt[2] - mark, 1);
    chk("coal_word", last_word[2], 16'h020C);

    // De-dup against shadow, then clamping.
    mark = word_cnt[1];
    req(1, 20);
    wait_idle();
    chk("dedup_count", word_cnt[1] - mark, 0);
    req(1, 40);
    wait_idle();
    chk("clamp_count", word_cnt[1] - mark, 1);
    chk("clamp_word", last_word[1], 16'h0220);

    // Round-robin after channel 1 was sent last.
    m_ready = 1'b0;
    req(1, 10);
    wait_valid(1);
    req(1, 11);
    req(0, 1);
    req(2, 2);
    req(3, 3);
    hs_addr.delete();
    hs_cyc.delete();
    m_ready = 1'b1;
    wait_idle();
    chk("rr_len", hs_addr.size(), 5);
    for (int k = 0; k < 5 && k < hs_addr.size(); k++)
      chk($sformatf("rr_order%0d", k), hs_addr[k], exp_ord[k]);
    for (int k = 1; k < hs_cyc.size(); k++)
      chk($sformatf("rr_spacing%0d", k), hs_cyc[k] - hs_cyc[k-1], 2);

    // Request landing on the same edge as the handshake of that channel.
    mark = word_cnt[3];
    m_ready = 1'b0;
    req(3, 7);
    wait_valid(3);
    chk("sim_data7", m_data, 16'h0207);
    s_valid = 1'b1; s_addr = 2'd3; s_atten = 6'd7; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    wait_idle();
    chk("sim_same_count", word_cnt[3] - mark, 1);
    mark = word_cnt[3];
    m_ready = 1'b0;
    req(3, 9);
    wait_valid(3);
    chk("sim_data9", m_data, 16'h0209);
    s_valid = 1'b1; s_addr = 2'd3; s_atten = 6'd8; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    wait_idle();
    chk("sim_diff_count", word_cnt[3] - mark, 2);
    chk("sim_diff_word", last_word[3], 16'h0208);
    check_shadow("directed");

    // Randomized traffic with random back-pressure.
    for (int k = 0; k < 400; k++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_addr  = 2'($urandom_range(0, 3));
      s_atten = 6'($urandom_range(0, 63));
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_idle();
    check_shadow("random");

    // Reset while a word is stalled: pending work dropped, INIT replays.
    m_ready = 1'b0;
    req(2, (desired[2] == 30) ? 31 : 30);
    req(1, (desired[1] == 5) ? 6 : 5);
    wait_valid(-1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_send_valid", m_valid, 0);
    chk("rst_send_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    wait_idle();
    chk("reinit_words", init_cnt, 4);
    chk("reinit_shadow", shadow_atten, {4{6'd20}});
    check_shadow("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
